// File: rtl/t_counter_if.sv
// Control/status bundle between a t_counter and its driver.
// The sclr signal exists only when T_COUNTER_SYNC_CLR_EN is defined.
interface t_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
`ifdef T_COUNTER_SYNC_CLR_EN
    logic             sclr;
`endif

    modport master (
`ifdef T_COUNTER_SYNC_CLR_EN
        output sclr,
`endif
        output en, up, load, load_val,
        input  count, t_vec, tc
    );

    modport slave (
`ifdef T_COUNTER_SYNC_CLR_EN
        input  sclr,
`endif
        input  en, up, load, load_val,
        output count, t_vec, tc
    );
endinterface

// File: rtl/t_counter.sv
// Modulo-MODULUS up/down counter producing a registered count, per-bit toggle vector and wrap pulse.
// Optional synchronous clear is compiled in with T_COUNTER_SYNC_CLR_EN.
module t_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic   clk,
    input  logic   reset_n,
    t_counter_if.slave bus
);
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] t_vec_q;
    logic             tc_q;

    logic [WIDTH:0]   cnt_w;
    logic [WIDTH:0]   nxt_w;
    logic [WIDTH-1:0] nxt;
    logic             wrap;

    assign cnt_w = {1'b0, count_q};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_w = cnt_w;
        wrap  = 1'b0;
`ifdef T_COUNTER_SYNC_CLR_EN
        if (bus.sclr) begin
            nxt_w = '0;
        end else
`endif
        if (bus.load) begin
            // Out-of-range load values clamp to the top of the count range.
            if ({1'b0, bus.load_val} >= MOD_W) nxt_w = MAX_W;
            else                              nxt_w = {1'b0, bus.load_val};
        end else if (bus.en) begin
            if (bus.up) begin
                if (cnt_w == MAX_W) begin
                    nxt_w = '0;
                    wrap  = 1'b1;
                end else begin
                    nxt_w = cnt_w + 1'b1;
                end
            end else begin
                if (cnt_w == '0) begin
                    nxt_w = MAX_W;
                    wrap  = 1'b1;
                end else begin
                    nxt_w = cnt_w - 1'b1;
                end
            end
        end
    end

    assign nxt = nxt_w[WIDTH-1:0];

    // NOTE: state registers use non-blocking assignments so all three update from the same old count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            t_vec_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= nxt;
            t_vec_q <= count_q ^ nxt;
            tc_q    <= wrap;
        end
    end

    assign bus.count = count_q;
    assign bus.t_vec = t_vec_q;
    assign bus.tc    = tc_q;
endmodule

// File: tb/tb_t_counter.sv
// Directed bench for t_counter (WIDTH=4, MODULUS=10); clear test runs when T_COUNTER_SYNC_CLR_EN is defined.
module tb_t_counter;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    t_counter_if #(.WIDTH(4)) bus ();

    t_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] c, input logic [3:0] t, input logic tc);
        checks++;
        if (bus.count !== c || bus.t_vec !== t || bus.tc !== tc) begin
            errors++;
            $display("FAIL %s: got count=%0d t_vec=%b tc=%b, need count=%0d t_vec=%b tc=%b",
                     name, bus.count, bus.t_vec, bus.tc, c, t, tc);
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load = 1'b1; bus.load_val = v; bus.en = 1'b0;
        step();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
`ifdef T_COUNTER_SYNC_CLR_EN
        bus.sclr = 1'b0;
`endif
        reset_n = 1'b0;
        #1;
        expect_out("reset_initial", 4'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.en = 1'b1;
        repeat (7) step();
        expect_out("reset_precount", 4'd7, 4'b0001 ^ 4'b0110 ^ 4'b0110 ^ 4'b0001 ^ 4'b0001, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("reset_async", 4'd0, 4'd0, 1'b0);
        step();
        expect_out("reset_held", 4'd0, 4'd0, 1'b0);
        bus.en = 1'b0;
        reset_n = 1'b1;
        step();
        expect_out("reset_release", 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic [3:0] exp_t [12] = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001, 4'b0011,
                                   4'b0001, 4'b1111, 4'b0001, 4'b1001, 4'b0001, 4'b0011};
        bus.en = 1'b1; bus.up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out($sformatf("up_wrap[%0d]", i), exp_c[i], exp_t[i], (i == 9));
        end
        bus.en = 1'b0;
    endtask

    task automatic test_down_wrap();
        do_load(4'd0);
        expect_out("down_preload0", 4'd0, 4'b0010, 1'b0);
        bus.en = 1'b1; bus.up = 1'b0;
        step();
        expect_out("down_wrap", 4'd9, 4'b1001, 1'b1);
        step();
        expect_out("down_after_wrap", 4'd8, 4'b0001, 1'b0);
        bus.en = 1'b0;
    endtask

    task automatic test_load();
        bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 4'd13;
        step();
        expect_out("load_clamp_13", 4'd9, 4'b0001, 1'b0);
        bus.load = 1'b0;
        step();
        expect_out("load_then_wrap", 4'd0, 4'b1001, 1'b1);
        // Load to 0 from 9 while enabled: would have wrapped, but load suppresses tc.
        bus.load = 1'b1; bus.load_val = 4'd9;
        step();
        expect_out("load_to_max", 4'd9, 4'b1001, 1'b0);
        bus.load_val = 4'd0;
        step();
        expect_out("load_to_zero_no_tc", 4'd0, 4'b1001, 1'b0);
        bus.load_val = 4'd15;
        step();
        expect_out("load_clamp_15", 4'd9, 4'b1001, 1'b0);
        bus.load = 1'b0; bus.en = 1'b0;
    endtask

    task automatic test_hold_dir();
        do_load(4'd5);
        expect_out("hold_preload5", 4'd5, 4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("hold[%0d]", i), 4'd5, 4'd0, 1'b0);
        end
        bus.en = 1'b1;
        bus.up = 1'b1; step(); expect_out("dir_up", 4'd6, 4'b0011, 1'b0);
        bus.up = 1'b0; step(); expect_out("dir_down", 4'd5, 4'b0011, 1'b0);
        bus.up = 1'b1; step(); expect_out("dir_up2", 4'd6, 4'b0011, 1'b0);
        bus.en = 1'b0;
    endtask

    task automatic test_tc_period();
        int pulses = 0;
        do_load(4'd0);
        bus.en = 1'b1; bus.up = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tc === 1'b1) pulses++;
        end
        bus.en = 1'b0;
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL tc_period: got %0d pulses in 30 cycles, need 3", pulses);
        end
        expect_out("tc_period_end", 4'd0, 4'b1001, 1'b1);
    endtask

`ifdef T_COUNTER_SYNC_CLR_EN
    task automatic test_clear();
        do_load(4'd6);
        bus.sclr = 1'b1; bus.load = 1'b1; bus.load_val = 4'd3; bus.en = 1'b1; bus.up = 1'b1;
        step();
        expect_out("clear_over_load", 4'd0, 4'b0110, 1'b0);
        bus.load = 1'b0; bus.up = 1'b0;
        step();
        expect_out("clear_over_down_wrap", 4'd0, 4'd0, 1'b0);
        bus.sclr = 1'b0; bus.en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_hold_dir();
        test_tc_period();
`ifdef T_COUNTER_SYNC_CLR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
